// File: rtl/spi_shift_engine.sv
// SPI master shift stage (CPHA=0): generates SCLK from a latched polarity/speed,
// shifts one frame MSB-first on MOSI and assembles the frame captured from MISO.
module spi_shift_engine #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  serclk_polarity,
  input  logic [3:0]            serclk_speed,
  input  logic                  miso,
  output logic                  sclk,
  output logic                  mosi,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  busy,
  output logic                  done,
  output logic                  set_inhibit
);

  localparam int EW = $clog2(2 * DATA_WIDTH + 1);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [4:0]            half_q, half_d;
  logic [4:0]            cnt_q, cnt_d;
  logic [EW-1:0]         edge_q, edge_d;
  logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_WIDTH-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  sclk_q, sclk_d;
  logic                  mosi_q, mosi_d;
  logic                  busy_q, busy_d;

  logic                  accept;
  logic                  tick;
  logic [EW-1:0]         edge_num;
  logic                  lead_edge;
  logic                  last_edge;

  // start is honoured in IDLE and in the single DONE cycle (back-to-back frames)
  assign accept    = start && (state_q != SHIFT);
  assign tick      = (state_q == SHIFT) && (cnt_q == 5'd0);
  assign edge_num  = edge_q + 1'b1;
  assign lead_edge = edge_num[0];
  assign last_edge = (edge_num == LAST_EDGE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (tick && last_edge) state_d = DONE;
      DONE:    state_d = start ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    half_d    = half_q;
    cnt_d     = cnt_q;
    edge_d    = edge_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    if (accept) begin
      half_d  = {1'b0, serclk_speed} + 5'd1;
      cnt_d   = {1'b0, serclk_speed};
      edge_d  = '0;
      tx_sh_d = tx_data;
      rx_sh_d = '0;
      sclk_d  = serclk_polarity;
      mosi_d  = tx_data[DATA_WIDTH-1];
      busy_d  = 1'b1;
    end else if (state_q == SHIFT) begin
      if (tick) begin
        // reload on the terminal count itself so the half-period never stretches
        cnt_d  = half_q - 5'd1;
        edge_d = edge_num;
        sclk_d = ~sclk_q;
        if (lead_edge) begin
          rx_sh_d = {rx_sh_q[DATA_WIDTH-2:0], miso};
        end else if (!last_edge) begin
          tx_sh_d = {tx_sh_q[DATA_WIDTH-2:0], 1'b0};
          mosi_d  = tx_sh_q[DATA_WIDTH-2];
        end
        if (last_edge) begin
          rx_data_d = rx_sh_q;
          busy_d    = 1'b0;
        end
      end else begin
        cnt_d = cnt_q - 5'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      half_q    <= '0;
      cnt_q     <= '0;
      edge_q    <= '0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      half_q    <= half_d;
      cnt_q     <= cnt_d;
      edge_q    <= edge_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
    end
  end

  // Idle SCLK follows the live polarity so config writes show up immediately
  always_comb begin
    done        = (state_q == DONE);
    busy        = busy_q;
    set_inhibit = busy_q;
    mosi        = mosi_q;
    rx_data     = rx_data_q;
    if (reset) begin
      sclk = 1'b0;
    end else if (state_q == SHIFT || state_q == DONE) begin
      sclk = sclk_q;
    end else begin
      sclk = serclk_polarity;
    end
  end

endmodule

// File: tb/tb_spi_shift_engine.sv
// Self-checking bench for spi_shift_engine: per-cycle SCLK/MOSI/busy/done
// timelines and received frames are predicted from the frame rules and compared.
module tb_spi_shift_engine;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] tx_data = '0;
  logic          serclk_polarity = 1'b1;
  logic [3:0]    serclk_speed = 4'd0;
  logic          miso = 1'b0;
  logic          sclk, mosi, busy, done, set_inhibit;
  logic [DW-1:0] rx_data;

  int tests = 0;
  int fails = 0;

  logic [4:0]    obs_v [0:599];
  logic [4:0]    exp_v [0:599];
  int            nobs;
  logic [DW-1:0] exp_rx = '0;
  logic [DW-1:0] exp_rx_prev, exp_rx_post, obs_rx_pre, obs_rx_post;

  spi_shift_engine #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .tx_data(tx_data),
    .serclk_polarity(serclk_polarity), .serclk_speed(serclk_speed), .miso(miso),
    .sclk(sclk), .mosi(mosi), .rx_data(rx_data), .busy(busy), .done(done),
    .set_inhibit(set_inhibit)
  );

  always #5 clk = ~clk;

  // Runs one frame, recording {sclk,mosi,busy,done,set_inhibit} after each edge T0+k
  // and the expected vector from the frame rules: toggles = k/H, bit index = toggles/2.
  task automatic drive_frame(input logic [DW-1:0] tx, input logic [DW-1:0] dev,
                             input bit loopb, input bit pol, input logic [3:0] spd,
                             input bit pre_started, input int ign_k, input int cfg_k,
                             input logic [3:0] cfg_spd, input bit cfg_pol,
                             input bit chain, input logic [DW-1:0] next_tx);
    int h, nb, t, i;
    bit s;
    h  = int'(spd) + 1;
    nb = 2 * DW * h;
    if (!pre_started) begin
      @(negedge clk);
      serclk_polarity = pol;
      serclk_speed    = spd;
      tx_data         = tx;
      start           = 1'b1;
    end
    exp_rx_prev = exp_rx;
    exp_rx_post = loopb ? tx : dev;
    nobs = chain ? nb + 1 : nb + 2;
    for (int k = 0; k < nobs; k++) begin
      @(posedge clk);
      #1;
      obs_v[k] = {sclk, mosi, busy, done, set_inhibit};
      t = k / h;
      i = t / 2;
      if (i > DW - 1) i = DW - 1;
      if (k <= nb) begin
        s = pol ^ t[0];
        exp_v[k] = {s, tx[DW-1-i], 1'(k < nb), 1'(k == nb), 1'(k < nb)};
      end else begin
        exp_v[k] = {serclk_polarity, tx[0], 3'b000};
      end
      if (k == nb - 1) obs_rx_pre = rx_data;
      if (k == nb) obs_rx_post = rx_data;
      miso  = loopb ? mosi : dev[DW-1-i];
      start = (k == ign_k) || (chain && k == nb);
      if (chain && k == nb) tx_data = next_tx;
      if (k == cfg_k) begin
        serclk_speed    = cfg_spd;
        serclk_polarity = cfg_pol;
      end
    end
    exp_rx = exp_rx_post;
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if ({sclk, mosi, busy, done, set_inhibit} !== 5'b00000) begin
      fails++;
      $display("FAIL reset_outputs {sclk,mosi,busy,done,inh} got %b exp 00000", {sclk, mosi, busy, done, set_inhibit});
    end
    tests++;
    if (rx_data !== '0) begin
      fails++;
      $display("FAIL reset_rx got %h exp 00", rx_data);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    tests++;
    if (sclk !== 1'b1) begin
      fails++;
      $display("FAIL idle_sclk_pol1 got %b exp 1", sclk);
    end
    serclk_polarity = 1'b0;
    #1;
    tests++;
    if (sclk !== 1'b0) begin
      fails++;
      $display("FAIL idle_sclk_pol0 got %b exp 0", sclk);
    end
  endtask

  task automatic test_loopback();
    drive_frame(8'hA5, 8'h00, 1'b1, 1'b0, 4'd0, 1'b0, -1, -1, 4'd0, 1'b0, 1'b0, 8'h00);
    for (int k = 0; k < nobs; k++) begin
      tests++;
      if (obs_v[k] !== exp_v[k]) begin
        fails++;
        $display("FAIL loopback_cycle k=%0d {sclk,mosi,busy,done,inh} got %b exp %b", k, obs_v[k], exp_v[k]);
      end
    end
    tests++;
    if (obs_rx_pre !== exp_rx_prev) begin
      fails++;
      $display("FAIL loopback_rx_early got %h exp %h", obs_rx_pre, exp_rx_prev);
    end
    tests++;
    if (obs_rx_post !== exp_rx_post) begin
      fails++;
      $display("FAIL loopback_rx got %h exp %h", obs_rx_post, exp_rx_post);
    end
  endtask

  task automatic test_polarity_speed();
    drive_frame(8'h3C, 8'hC3, 1'b0, 1'b1, 4'd3, 1'b0, -1, -1, 4'd0, 1'b0, 1'b0, 8'h00);
    for (int k = 0; k < nobs; k++) begin
      tests++;
      if (obs_v[k] !== exp_v[k]) begin
        fails++;
        $display("FAIL pol1_spd3_cycle k=%0d {sclk,mosi,busy,done,inh} got %b exp %b", k, obs_v[k], exp_v[k]);
      end
    end
    tests++;
    if (obs_rx_post !== exp_rx_post) begin
      fails++;
      $display("FAIL pol1_spd3_rx got %h exp %h", obs_rx_post, exp_rx_post);
    end
  endtask

  task automatic test_config_change();
    logic [DW-1:0] tx;
    tx = DW'($urandom);
    drive_frame(tx, 8'h00, 1'b1, 1'b0, 4'd0, 1'b0, -1, 5, 4'd15, 1'b1, 1'b0, 8'h00);
    for (int k = 0; k < nobs; k++) begin
      tests++;
      if (obs_v[k] !== exp_v[k]) begin
        fails++;
        $display("FAIL cfg_locked_cycle k=%0d {sclk,mosi,busy,done,inh} got %b exp %b", k, obs_v[k], exp_v[k]);
      end
    end
    drive_frame(8'h96, 8'h5A, 1'b0, 1'b1, 4'd15, 1'b0, -1, -1, 4'd0, 1'b0, 1'b0, 8'h00);
    for (int k = 0; k < nobs; k++) begin
      tests++;
      if (obs_v[k] !== exp_v[k]) begin
        fails++;
        $display("FAIL cfg_new_h16_cycle k=%0d {sclk,mosi,busy,done,inh} got %b exp %b", k, obs_v[k], exp_v[k]);
      end
    end
    tests++;
    if (obs_rx_post !== exp_rx_post) begin
      fails++;
      $display("FAIL cfg_new_h16_rx got %h exp %h", obs_rx_post, exp_rx_post);
    end
  endtask

  task automatic test_back_to_back();
    drive_frame(8'h4E, 8'hB1, 1'b0, 1'b0, 4'd1, 1'b0, 3, -1, 4'd0, 1'b0, 1'b1, 8'h81);
    for (int k = 0; k < nobs; k++) begin
      tests++;
      if (obs_v[k] !== exp_v[k]) begin
        fails++;
        $display("FAIL b2b_first_cycle k=%0d {sclk,mosi,busy,done,inh} got %b exp %b", k, obs_v[k], exp_v[k]);
      end
    end
    tests++;
    if (obs_rx_post !== exp_rx_post) begin
      fails++;
      $display("FAIL b2b_first_rx got %h exp %h", obs_rx_post, exp_rx_post);
    end
    drive_frame(8'h81, 8'h7E, 1'b0, 1'b0, 4'd1, 1'b1, -1, -1, 4'd0, 1'b0, 1'b0, 8'h00);
    for (int k = 0; k < nobs; k++) begin
      tests++;
      if (obs_v[k] !== exp_v[k]) begin
        fails++;
        $display("FAIL b2b_second_cycle k=%0d {sclk,mosi,busy,done,inh} got %b exp %b", k, obs_v[k], exp_v[k]);
      end
    end
    tests++;
    if (obs_rx_pre !== exp_rx_prev) begin
      fails++;
      $display("FAIL b2b_second_rx_early got %h exp %h", obs_rx_pre, exp_rx_prev);
    end
    tests++;
    if (obs_rx_post !== exp_rx_post) begin
      fails++;
      $display("FAIL b2b_second_rx got %h exp %h", obs_rx_post, exp_rx_post);
    end
  endtask

  task automatic test_reset_midframe();
    int bad;
    drive_frame(8'h55, 8'h00, 1'b1, 1'b1, 4'd0, 1'b0, -1, -1, 4'd0, 1'b0, 1'b0, 8'h00);
    tests++;
    if (obs_rx_post !== 8'h55) begin
      fails++;
      $display("FAIL midreset_setup_rx got %h exp 55", obs_rx_post);
    end
    @(negedge clk);
    tx_data = 8'hFF;
    start   = 1'b1;
    for (int k = 0; k <= 7; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    reset = 1'b1;
    #1;
    tests++;
    if ({sclk, mosi, busy, done, set_inhibit} !== 5'b00000) begin
      fails++;
      $display("FAIL midreset_outputs {sclk,mosi,busy,done,inh} got %b exp 00000", {sclk, mosi, busy, done, set_inhibit});
    end
    tests++;
    if (rx_data !== '0) begin
      fails++;
      $display("FAIL midreset_rx got %h exp 00", rx_data);
    end
    exp_rx = '0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    tests++;
    if (sclk !== serclk_polarity) begin
      fails++;
      $display("FAIL midreset_idle_sclk got %b exp %b", sclk, serclk_polarity);
    end
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL midreset_no_done got %0d active cycles exp 0", bad);
    end
  endtask

  task automatic test_random();
    bit            pend, loopb, pol, chain;
    logic [3:0]    spd;
    logic [DW-1:0] tx, dev, ntx;
    int            ign;
    pend = 1'b0;
    ntx  = '0;
    for (int f = 0; f < 12; f++) begin
      dev   = DW'($urandom);
      loopb = 1'($urandom_range(0, 1));
      if (pend) begin
        tx  = ntx;
        pol = serclk_polarity;
        spd = serclk_speed;
      end else begin
        tx  = DW'($urandom);
        pol = 1'($urandom_range(0, 1));
        spd = 4'($urandom_range(0, 3));
      end
      chain = (f < 11) && ($urandom_range(0, 1) == 1);
      ntx   = DW'($urandom);
      ign   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 2 * DW - 1)) : -1;
      drive_frame(tx, dev, loopb, pol, spd, pend, ign, -1, 4'd0, 1'b0, chain, ntx);
      for (int k = 0; k < nobs; k++) begin
        tests++;
        if (obs_v[k] !== exp_v[k]) begin
          fails++;
          $display("FAIL random_cycle f=%0d k=%0d {sclk,mosi,busy,done,inh} got %b exp %b", f, k, obs_v[k], exp_v[k]);
        end
      end
      tests++;
      if (obs_rx_post !== exp_rx_post) begin
        fails++;
        $display("FAIL random_rx f=%0d got %h exp %h", f, obs_rx_post, exp_rx_post);
      end
      pend = chain;
    end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_polarity_speed();
    test_config_change();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
